// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, opcodes, operand selects and decoded-entry types
package alu_pkg;
  localparam logic [3:0] ALU_OP_AND  = 4'b0000;
  localparam logic [3:0] ALU_OP_OR   = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
  localparam logic [3:0] ALU_OP_SRL  = 4'b1000;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1001;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0101;
  localparam logic [3:0] ALU_OP_SLT  = 4'b1100;
  localparam logic [3:0] ALU_OP_SLTU = 4'b1101;
  localparam logic [3:0] ALU_OP_SLL  = 4'b1010;
  localparam logic [3:0] ALU_OP_NOP  = 4'b1111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [1:0] IN1_RS1  = 2'd0;
  localparam logic [1:0] IN1_PC   = 2'd1;
  localparam logic [1:0] IN1_ZERO = 2'd2;
  localparam logic IN2_RS2 = 1'b0;
  localparam logic IN2_IMM = 1'b1;
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [1:0]  in1_sel;
    logic        in2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        branch;
    logic        branch_inv;
    logic        illegal;
  } dec_t;
  typedef struct packed {
    dec_t        dec;
    logic [31:0] pc;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
  localparam logic [ENTRY_W-1:0] ENTRY_RST = {ALU_OP_NOP, {(ENTRY_W-4){1'b0}}};
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  arith_op = ALU_OP_SLL;
      3'b010:  arith_op = ALU_OP_SLT;
      3'b011:  arith_op = ALU_OP_SLTU;
      3'b100:  arith_op = ALU_OP_XOR;
      3'b101:  arith_op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  arith_op = ALU_OP_OR;
      default: arith_op = ALU_OP_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: RV32I instruction to ALU op/selects/immediate; ALU_ILLEGAL_CHECK_EN flags unsupported encodings
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic sh, unsup;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign sh = f3[1:0] == 2'b01;
  // decode opcode into ALU op, operand selects and immediate
  always_comb begin
    dec = '0;
    dec.alu_op = ALU_OP_NOP;
    dec.rd = instr[11:7];
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    unsup = 1'b0;
    case (opc)
      OPC_OP: begin
        unsup = !(f7 == 7'b0000000 || f7 == 7'b0100000);
        dec.alu_op = arith_op(f3, instr[30]);
      end
      OPC_OP_IMM: begin
        dec.alu_op = arith_op(f3, sh & instr[30]);
        dec.in2_sel = IN2_IMM;
        dec.imm = sh ? {27'b0, instr[24:20]} : imm_i;
`ifdef ALU_ILLEGAL_CHECK_EN
        unsup = sh & instr[25];
`endif
      end
      OPC_LUI: begin
        dec.alu_op = ALU_OP_ADD;
        dec.in1_sel = IN1_ZERO;
        dec.in2_sel = IN2_IMM;
        dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        dec.alu_op = ALU_OP_ADD;
        dec.in1_sel = IN1_PC;
        dec.in2_sel = IN2_IMM;
        dec.imm = imm_u;
      end
      OPC_LOAD, OPC_JALR: begin
        dec.alu_op = ALU_OP_ADD;
        dec.in2_sel = IN2_IMM;
        dec.imm = imm_i;
      end
      OPC_STORE: begin
        dec.alu_op = ALU_OP_ADD;
        dec.in2_sel = IN2_IMM;
        dec.imm = imm_s;
      end
      OPC_JAL: begin
        dec.alu_op = ALU_OP_ADD;
        dec.in1_sel = IN1_PC;
        dec.in2_sel = IN2_IMM;
        dec.imm = imm_j;
      end
      OPC_BRANCH: begin
        unsup = f3[2:1] == 2'b01;
        dec.alu_op = !f3[2] ? ALU_OP_SUB : f3[1] ? ALU_OP_SLTU : ALU_OP_SLT;
        dec.branch = 1'b1;
        dec.branch_inv = f3[2] ? f3[0] : !f3[0];
        dec.imm = imm_b;
      end
      OPC_FENCE, OPC_SYSTEM: dec.imm = imm_i;
      default: unsup = 1'b1;
    endcase
    if (unsup) begin
      dec.alu_op = ALU_OP_NOP;
      dec.in1_sel = IN1_RS1;
      dec.in2_sel = IN2_RS2;
      dec.imm = '0;
      dec.branch = 1'b0;
      dec.branch_inv = 1'b0;
    end
`ifdef ALU_ILLEGAL_CHECK_EN
    dec.illegal = unsup;
`else
    dec.illegal = 1'b0;
`endif
  end
endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: decode/issue stage with output register and one-entry skid buffer (ALU_ILLEGAL_CHECK_EN enables illegal flag)
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [1:0]      in1_sel,
  output logic            in2_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            branch,
  output logic            branch_inv,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  entry_t ob, ob_n, sb, sb_n, nw;
  dec_t dec;
  logic rdy_q, acc, pop;
  alu_op_decode u_dec (.instr(in_instr), .dec(dec));
  assign nw = {dec, in_pc};
  assign acc = in_valid & rdy_q & !flush;
  assign pop = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign in_ready = rdy_q;
  assign {alu_op, in1_sel, in2_sel, imm, rs1, rs2, rd, branch, branch_inv, illegal} = ob.dec;
  assign out_pc = ob.pc;
  // next entry count and storage contents; ob always holds the oldest entry
  always_comb begin
    state_n = state;
    ob_n = ob;
    sb_n = sb;
    case (state)
      EMPTY: begin
        state_n = acc ? ONE : EMPTY;
        ob_n = acc ? nw : ob;
      end
      ONE: begin
        state_n = acc && !pop ? TWO : pop && !acc ? EMPTY : ONE;
        ob_n = acc && pop ? nw : ob;
        sb_n = acc && !pop ? nw : sb;
      end
      TWO: begin
        state_n = pop ? ONE : TWO;
        ob_n = pop ? sb : ob;
      end
      default: state_n = EMPTY;
    endcase
    if (flush) state_n = EMPTY;
  end
  // state, storage and registered ready (ready drops only while the skid entry is full)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      ob <= ENTRY_RST;
      sb <= ENTRY_RST;
      rdy_q <= 1'b1;
    end else begin
      state <= state_n;
      ob <= ob_n;
      sb <= sb_n;
      rdy_q <= state_n != TWO;
    end
  end
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed self-checking bench for alu_op_issue
module tb_alu_op_issue;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, imm, out_pc;
  logic [3:0] alu_op;
  logic [1:0] in1_sel;
  logic in2_sel, branch, branch_inv, illegal;
  logic [4:0] rs1, rs2, rd;
  int checks = 0;
  int errors = 0;
  alu_op_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .in1_sel(in1_sel), .in2_sel(in2_sel), .imm(imm), .rs1(rs1),
    .rs2(rs2), .rd(rd), .branch(branch), .branch_inv(branch_inv), .out_pc(out_pc),
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    in_instr = i;
    in_pc = p;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_instr = '0;
    in_pc = '0;
    tick();
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL reset_hs got valid/ready=%b exp 01", {out_valid, in_ready}); end
    checks++;
    if (alu_op !== 4'hF) begin errors++; $display("FAIL reset_aluop got %h exp f", alu_op); end
    checks++;
    if ({in1_sel, in2_sel, imm, rs1, rs2, rd, branch, branch_inv, out_pc, illegal} !== '0) begin
      errors++; $display("FAIL reset_fields got imm=%h pc=%h sel=%b%b nonzero", imm, out_pc, in1_sel, in2_sel);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_add_sub;
    send(32'h002081B3, 32'h100);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
    checks++;
    if ({alu_op, in1_sel, in2_sel} !== {4'b0010, 2'd0, 1'b0}) begin errors++; $display("FAIL add_op got %h/%0d/%0d exp 2/0/0", alu_op, in1_sel, in2_sel); end
    checks++;
    if ({rd, rs1, rs2} !== {5'd3, 5'd1, 5'd2}) begin errors++; $display("FAIL add_regs got rd=%0d rs1=%0d rs2=%0d exp 3 1 2", rd, rs1, rs2); end
    checks++;
    if (out_pc !== 32'h100) begin errors++; $display("FAIL add_pc got %h exp 00000100", out_pc); end
    send(32'h402081B3, 32'h104);
    checks++;
    if (alu_op !== 4'b0110) begin errors++; $display("FAIL sub_op got %b exp 0110", alu_op); end
    checks++;
    if (out_pc !== 32'h104) begin errors++; $display("FAIL sub_pc got %h exp 00000104", out_pc); end
  endtask
  task automatic test_srai;
    send(32'h40335293, 32'h108);
    checks++;
    if ({alu_op, in2_sel, rd} !== {4'b1001, 1'b1, 5'd5}) begin errors++; $display("FAIL srai_op got op=%b in2=%b rd=%0d exp 1001 1 5", alu_op, in2_sel, rd); end
    checks++;
    if (imm !== 32'h3) begin errors++; $display("FAIL srai_imm got %h exp 00000003", imm); end
  endtask
  task automatic test_branch;
    send(32'hFE209EE3, 32'h10C);
    checks++;
    if ({alu_op, branch, branch_inv} !== {4'b0110, 2'b10}) begin errors++; $display("FAIL bne_op got op=%b br=%b inv=%b exp 0110 1 0", alu_op, branch, branch_inv); end
    checks++;
    if (imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL bne_imm got %h exp fffffffc", imm); end
    checks++;
    if (in2_sel !== 1'b0) begin errors++; $display("FAIL bne_in2 got %b exp 0", in2_sel); end
    send(32'hFE20FEE3, 32'h110);
    checks++;
    if ({alu_op, branch, branch_inv} !== {4'b1101, 2'b11}) begin errors++; $display("FAIL bgeu_op got op=%b br=%b inv=%b exp 1101 1 1", alu_op, branch, branch_inv); end
  endtask
  task automatic test_formats;
    send(32'h123450B7, 32'h114);
    checks++;
    if ({alu_op, in1_sel, in2_sel, imm} !== {4'b0010, 2'd2, 1'b1, 32'h12345000}) begin errors++; $display("FAIL lui got op=%b in1=%0d in2=%0d imm=%h exp 0010 2 1 12345000", alu_op, in1_sel, in2_sel, imm); end
    send(32'h0020A423, 32'h118);
    checks++;
    if ({alu_op, in1_sel, in2_sel, imm, rs2} !== {4'b0010, 2'd0, 1'b1, 32'h8, 5'd2}) begin errors++; $display("FAIL sw got op=%b in1=%0d in2=%0d imm=%h rs2=%0d exp 0010 0 1 8 2", alu_op, in1_sel, in2_sel, imm, rs2); end
    send(32'h00001097, 32'h11C);
    checks++;
    if ({alu_op, in1_sel, in2_sel, imm} !== {4'b0010, 2'd1, 1'b1, 32'h1000}) begin errors++; $display("FAIL auipc got op=%b in1=%0d in2=%0d imm=%h exp 0010 1 1 00001000", alu_op, in1_sel, in2_sel, imm); end
  endtask
  task automatic test_illegal;
    logic exp_ill;
`ifdef ALU_ILLEGAL_CHECK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    send(32'h0000007F, 32'h120);
    checks++;
    if ({out_valid, alu_op, branch} !== {1'b1, 4'hF, 1'b0}) begin errors++; $display("FAIL badopc got valid=%b op=%h br=%b exp 1 f 0", out_valid, alu_op, branch); end
    checks++;
    if (illegal !== exp_ill) begin errors++; $display("FAIL badopc_ill got %b exp %b", illegal, exp_ill); end
    send(32'h022081B3, 32'h124);
    checks++;
    if ({alu_op, illegal} !== {4'hF, exp_ill}) begin errors++; $display("FAIL badf7 got op=%h ill=%b exp f %b", alu_op, illegal, exp_ill); end
  endtask
  task automatic test_back_to_back;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    in_pc = 32'h200;
    tick();
    checks++;
    if ({out_valid, in_ready, out_pc, alu_op} !== {2'b11, 32'h200, 4'b0010}) begin errors++; $display("FAIL bp_a got valid=%b rdy=%b pc=%h op=%b exp 1 1 200 0010", out_valid, in_ready, out_pc, alu_op); end
    in_instr = 32'h402081B3;
    in_pc = 32'h204;
    tick();
    checks++;
    if ({in_ready, out_pc} !== {1'b0, 32'h200}) begin errors++; $display("FAIL bp_full got rdy=%b pc=%h exp 0 200", in_ready, out_pc); end
    in_instr = 32'h0020C1B3;
    in_pc = 32'h208;
    tick();
    checks++;
    if ({in_ready, out_pc, alu_op} !== {1'b0, 32'h200, 4'b0010}) begin errors++; $display("FAIL bp_hold1 got rdy=%b pc=%h op=%b exp 0 200 0010", in_ready, out_pc, alu_op); end
    tick();
    checks++;
    if ({out_valid, in_ready, out_pc} !== {2'b10, 32'h200}) begin errors++; $display("FAIL bp_hold2 got valid=%b rdy=%b pc=%h exp 1 0 200", out_valid, in_ready, out_pc); end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready, out_pc, alu_op} !== {2'b11, 32'h204, 4'b0110}) begin errors++; $display("FAIL bp_b got valid=%b rdy=%b pc=%h op=%b exp 1 1 204 0110", out_valid, in_ready, out_pc, alu_op); end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_pc, alu_op} !== {1'b1, 32'h208, 4'b0101}) begin errors++; $display("FAIL bp_c got valid=%b pc=%h op=%b exp 1 208 0101", out_valid, out_pc, alu_op); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got valid=%b exp 0", out_valid); end
  endtask
  task automatic test_flush;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    in_pc = 32'h300;
    tick();
    in_pc = 32'h304;
    tick();
    in_pc = 32'h308;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_two got valid=%b rdy=%b exp 0 1", out_valid, in_ready); end
    in_valid = 1'b1;
    in_pc = 32'h30C;
    tick();
    in_pc = 32'h310;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_one got valid=%b rdy=%b exp 0 1", out_valid, in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got valid=%b pc=%h exp 0", out_valid, out_pc); end
  endtask
  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h402081B3;
    in_pc = 32'h400;
    tick();
    in_pc = 32'h404;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_pre got valid=%b rdy=%b exp 1 0", out_valid, in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, alu_op, out_pc} !== {2'b01, 4'hF, 32'h0}) begin errors++; $display("FAIL rstmid got valid=%b rdy=%b op=%h pc=%h exp 0 1 f 0", out_valid, in_ready, alu_op, out_pc); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_post got valid=%b exp 0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_add_sub();
    test_srai();
    test_branch();
    test_formats();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Decode/issue stage that turns a fetched RV32I instruction into the 4-bit ALU operation code, operand selects and immediate consumed by the execute-stage ALU.
- Sits between fetch and execute; it is the producer of the ALU operation encoding.
- Valid/ready handshake on both sides.
- Registered output plus a one-entry skid buffer, so the input side accepts at full rate under single-cycle backpressure.

Parameters:
XLEN, 32, datapath width of pc and imm (fixed at 32 for RV32I).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instr/pc valid
in_ready  output  1  stage can accept
in_instr  input  32  raw instruction
in_pc  input  32  instruction address
flush  input  1  discard all held entries (taken branch/jump)
out_valid  output  1  decoded entry valid
out_ready  input  1  execute stage accepts
alu_op  output  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SRL 1000, SRA 1001, XOR 0101, SLT 1100, SLTU 1101, SLL 1010, NOP 1111
in1_sel  output  2  0 rs1, 1 pc, 2 zero
in2_sel  output  1  0 rs2, 1 imm
imm  output  32  sign-extended immediate; shifts: zero-extended shamt[4:0]
rs1, rs2, rd  output  5 each  register indices
branch  output  1  conditional branch
branch_inv  output  1  take branch when ALU zero/result is false
out_pc  output  32  pc of entry
illegal  output  1  unsupported encoding

Behaviour:
- Reset (async, rst=1): both entries invalid; out_valid=0; in_ready=1; alu_op=1111; all other outputs 0. Release takes effect at the next clk edge.
- Reset mid-operation discards all entries; no partial outputs remain.
- Transfer occurs on a clk edge when valid && ready. Latency: an accepted instruction appears on the outputs the cycle after acceptance at the earliest.
- in_ready is a registered signal, equal to !skid_full. It never depends combinationally on out_ready.
- State machine (entries held):
  - EMPTY: accept -> ONE.
  - ONE: accept and not pop -> TWO; pop and not accept -> EMPTY; both -> ONE.
  - TWO: pop -> ONE; in_ready=0.
- Outputs always present the oldest entry. Order is strictly preserved.
- Output fields are held stable while out_valid && !out_ready.
- flush=1: next state EMPTY regardless of in_valid/out_ready. An input offered in the same cycle is dropped (not accepted). in_ready=1 the next cycle.
- Decode table (alu_op, in1_sel, in2_sel):
  - OP: funct3/funct7 -> ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, in1=rs1, in2=rs2.
  - OP-IMM: same ops, in2=imm; funct7[5] is honoured only for SRLI/SRAI.
  - LUI: ADD, zero, imm.
  - AUIPC: ADD, pc, imm.
  - LOAD/STORE: ADD, rs1, imm.
  - JAL: ADD, pc, imm.
  - JALR: ADD, rs1, imm.
  - BRANCH: BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLTU; in2=rs2; branch=1; branch_inv=1 for BEQ, BGE, BGEU.
  - FENCE/SYSTEM: NOP.
- Immediates follow the I/S/B/U/J formats, sign-extended from instr[31]. For SLLI/SRLI/SRAI, imm = {27'b0, instr[24:20]}.
- Unsupported opcode, or OP with funct7 not in {0000000, 0100000}: alu_op=1111 (see feature).

Optional Feature:
- ALU_ILLEGAL_CHECK_EN
  - Defined: illegal=1 for unsupported opcodes, bad funct7, and OP-IMM shifts with instr[25]=1. alu_op=1111 and branch=0 for such entries. The entry still flows through the handshake.
  - Undefined: illegal is tied 0; unsupported encodings silently decode to NOP.

Decomposition:
- Package alu_pkg holds:
  - the ALU_OP_* 4-bit constants;
  - the OPC_* 7-bit opcode constants;
  - the in1_sel/in2_sel codes;
  - the decoded-entry struct/width constant used to size both storage registers.
- One combinational sub-module, alu_op_decode: instr in, decoded entry out.
- alu_op_issue wraps alu_op_decode with the output/skid registers and the handshake FSM.

Test Plan:
- ADD x3,x1,x2 (0x002081B3, pc 0x100), out_ready=1 -> next cycle out_valid=1, alu_op=0010, in1_sel=0, in2_sel=0, rd=3, rs1=1, rs2=2, out_pc=0x100.
- SUB 0x402081B3 -> alu_op=0110. SRAI x5,x6,3 (0x40335293) -> alu_op=1001, in2_sel=1, imm=0x00000003, rd=5.
- BNE x1,x2,-4 (0xFE209EE3) -> alu_op=0110, branch=1, branch_inv=0, imm=0xFFFFFFFC. BGEU -> alu_op=1101, branch_inv=1.
- Backpressure: out_ready=0 for 3 cycles with back-to-back in_valid (instr A, B, C) -> A and B accepted, in_ready=0 from the cycle after B, C held. After out_ready=1, outputs present A, B, C in order, none lost or duplicated.
- Flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered instr not accepted.
- rst asserted mid-stream (state TWO) -> out_valid=0, alu_op=1111, in_ready=1 immediately. Opcode 0x0000007F with ALU_ILLEGAL_CHECK_EN defined -> illegal=1, alu_op=1111.
